// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS sequencer and its datapath.
// The controller is the master; the datapath supplies IR fields, the ALU zero flag and memory handshake.
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       MemRE;
  logic       MemWE;
  logic       IorD;
  logic       IRWE;
  logic       PCWE;
  logic [1:0] PCSrc;
  logic       RFWE;
  logic       RFDSel;
  logic       MtoRFSel;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [3:0] ALUsel;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output MemRE, MemWE, IorD, IRWE, PCWE, PCSrc, RFWE, RFDSel, MtoRFSel,
           ALUSrcA, ALUSrcB, ALUsel, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  MemRE, MemWE, IorD, IRWE, PCWE, PCSrc, RFWE, RFDSel, MtoRFSel,
           ALUSrcA, ALUSrcB, ALUsel, illegal, state
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Moore sequencer for the shared-memory multicycle MIPS datapath.
// Steps fetch/decode/execute/memory/writeback, stalls on mem_ready, flags unsupported encodings.
module mips_multicycle_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  mips_multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12,
    S_ILL    = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // Write enables that depend on same-cycle inputs are stored as qualifiers
  // and gated combinationally with mem_ready / zero at the outputs.
  typedef struct packed {
    logic       memre;
    logic       memwe;
    logic       iord;
    logic       irwe_rdy;
    logic       pcwe_rdy;
    logic       pcwe_zero;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic       rfwe;
    logic       rfdsel;
    logic       mtorfsel;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] alusel;
    logic       illegal;
  } ctl_t;

  state_t     state_q, state_d;
  ctl_t       ctl_q, ctl_d;
  logic       is_sw_q;
  logic       funct_ok_q;
  logic [3:0] funct_alu;
  logic       funct_ok;

  always_comb begin
    funct_alu = ALU_AND;
    funct_ok  = 1'b1;
    case (bus.funct)
      6'h20:   funct_alu = ALU_ADD;
      6'h22:   funct_alu = ALU_SUB;
      6'h24:   funct_alu = ALU_AND;
      6'h25:   funct_alu = ALU_OR;
      6'h27:   funct_alu = ALU_NOR;
      6'h2A:   funct_alu = ALU_SLT;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH:  state_d = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILL;
        endcase
      end
      S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = funct_ok_q ? S_ALUWB : S_ILL;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Outputs are decoded from the state being entered so they are registered
  // alongside it; EXEC is only entered from DECODE, where funct is already valid.
  always_comb begin
    ctl_d = '0;
    case (state_d)
      S_FETCH: begin
        ctl_d.memre    = 1'b1;
        ctl_d.alusrcb  = 2'b01;
        ctl_d.alusel   = ALU_ADD;
        ctl_d.irwe_rdy = 1'b1;
        ctl_d.pcwe_rdy = 1'b1;
      end
      S_DECODE: begin
        ctl_d.alusrcb = 2'b11;
        ctl_d.alusel  = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctl_d.alusrca = 1'b1;
        ctl_d.alusrcb = 2'b10;
        ctl_d.alusel  = ALU_ADD;
      end
      S_MEMRD: begin
        ctl_d.memre = 1'b1;
        ctl_d.iord  = 1'b1;
      end
      S_MEMWB: begin
        ctl_d.rfwe     = 1'b1;
        ctl_d.mtorfsel = 1'b1;
      end
      S_MEMWR: begin
        ctl_d.memwe = 1'b1;
        ctl_d.iord  = 1'b1;
      end
      S_EXEC: begin
        ctl_d.alusrca = 1'b1;
        ctl_d.alusel  = funct_alu;
      end
      S_ALUWB: begin
        ctl_d.rfwe   = 1'b1;
        ctl_d.rfdsel = 1'b1;
      end
      S_BRANCH: begin
        ctl_d.alusrca   = 1'b1;
        ctl_d.alusel    = ALU_SUB;
        ctl_d.pcsrc     = 2'b01;
        ctl_d.pcwe_zero = 1'b1;
      end
      S_ADDIWB: ctl_d.rfwe = 1'b1;
      S_JUMP: begin
        ctl_d.pcsrc = 2'b10;
        ctl_d.pcwe  = 1'b1;
      end
      S_ILL:   ctl_d.illegal = 1'b1;
      default: ctl_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RST;
      ctl_q      <= '0;
      is_sw_q    <= 1'b0;
      funct_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_d;
      if (state_q == S_DECODE) begin
        is_sw_q    <= (bus.opcode == OP_SW);
        funct_ok_q <= funct_ok;
      end
    end
  end

  assign bus.MemRE    = ctl_q.memre;
  assign bus.MemWE    = ctl_q.memwe;
  assign bus.IorD     = ctl_q.iord;
  assign bus.IRWE     = ctl_q.irwe_rdy & bus.mem_ready;
  assign bus.PCWE     = ctl_q.pcwe
                      | (ctl_q.pcwe_rdy & bus.mem_ready)
                      | (ctl_q.pcwe_zero & bus.zero);
  assign bus.PCSrc    = ctl_q.pcsrc;
  assign bus.RFWE     = ctl_q.rfwe;
  assign bus.RFDSel   = ctl_q.rfdsel;
  assign bus.MtoRFSel = ctl_q.mtorfsel;
  assign bus.ALUSrcA  = ctl_q.alusrca;
  assign bus.ALUSrcB  = ctl_q.alusrcb;
  assign bus.ALUsel   = ctl_q.alusel;
  assign bus.illegal  = ctl_q.illegal;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized instruction-level bench for mips_multicycle_ctrl against a per-instruction
// state-sequence model; a few directed tests pin CPI, stalls and reset with literals.
module tb_mips_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [21:0] exp_v;
  logic [21:0] exp_m;
  logic        exp_valid = 1'b0;
  logic [5:0]  cur_op;
  logic [5:0]  cur_fn;

  logic [21:0] dv;
  assign dv = {bus.MemRE, bus.MemWE, bus.IorD, bus.IRWE, bus.PCWE, bus.PCSrc,
               bus.RFWE, bus.RFDSel, bus.MtoRFSel, bus.ALUSrcA, bus.ALUSrcB,
               bus.ALUsel, bus.illegal, bus.state};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, expv);
    end
  endtask

  // {valid, alusel} for an R-type funct
  function automatic logic [4:0] alu_of(input logic [5:0] fn);
    case (fn)
      6'h20:   return 5'b1_0010;
      6'h22:   return 5'b1_0110;
      6'h24:   return 5'b1_0000;
      6'h25:   return 5'b1_0001;
      6'h27:   return 5'b1_1100;
      6'h2A:   return 5'b1_0111;
      default: return 5'b0_0000;
    endcase
  endfunction

  // Output vector the datapath must see while in state st.
  function automatic logic [21:0] spec_out(input logic [3:0] st, input logic mr,
                                           input logic z, input logic [5:0] fn);
    logic re, we, iord, irwe, pcwe, rfwe, rfd, m2r, sa, il;
    logic [1:0] pcsrc, sb;
    logic [3:0] alu;
    logic [4:0] af;
    re = 0; we = 0; iord = 0; irwe = 0; pcwe = 0; rfwe = 0; rfd = 0; m2r = 0;
    sa = 0; il = 0; pcsrc = 0; sb = 0; alu = 0;
    af = alu_of(fn);
    case (st)
      4'd1:  begin re = 1; sb = 2'b01; alu = 4'b0010; irwe = mr; pcwe = mr; end
      4'd2:  begin sb = 2'b11; alu = 4'b0010; end
      4'd3:  begin sa = 1; sb = 2'b10; alu = 4'b0010; end
      4'd4:  begin re = 1; iord = 1; end
      4'd5:  begin rfwe = 1; m2r = 1; end
      4'd6:  begin we = 1; iord = 1; end
      4'd7:  begin sa = 1; alu = af[3:0]; end
      4'd8:  begin rfwe = 1; rfd = 1; end
      4'd9:  begin sa = 1; alu = 4'b0110; pcsrc = 2'b01; pcwe = z; end
      4'd10: begin sa = 1; sb = 2'b10; alu = 4'b0010; end
      4'd11: rfwe = 1;
      4'd12: begin pcsrc = 2'b10; pcwe = 1; end
      4'd13: il = 1;
      default: ;
    endcase
    return {re, we, iord, irwe, pcwe, pcsrc, rfwe, rfd, m2r, sa, sb, alu, il, st};
  endfunction

  always @(negedge clk) begin
    #2;
    if (exp_valid) begin
      chk("cycle_outputs", dv & ~exp_m, exp_v & ~exp_m);
      chk("rf_mem_exclusive", bus.RFWE & bus.MemWE, 0);
      chk("pcwe_state", bus.PCWE & !(bus.state inside {4'd1, 4'd9, 4'd12}), 0);
    end
  end

  task automatic cyc(input logic [3:0] st, input logic mr);
    logic [4:0] af;
    @(negedge clk);
    bus.mem_ready = mr;
    bus.zero      = 1'($urandom);
    if (st == 4'd1) begin
      bus.opcode = 6'($urandom);
      bus.funct  = 6'($urandom);
    end else begin
      bus.opcode = cur_op;
      bus.funct  = cur_fn;
    end
    af = alu_of(cur_fn);
    exp_v = spec_out(st, mr, bus.zero, cur_fn);
    exp_m = (st == 4'd7 && !af[4]) ? 22'h0001E0 : 22'h0;
    exp_valid = 1'b1;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic int stalls();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
  endfunction

  task automatic rand_instr();
    int k;
    int s;
    logic [5:0] v;
    k = $urandom_range(0, 7);
    cur_fn = 6'($urandom);
    case (k)
      0: cur_op = 6'h23;
      1: cur_op = 6'h2B;
      2: begin
        cur_op = 6'h00;
        case ($urandom_range(0, 5))
          0: cur_fn = 6'h20;
          1: cur_fn = 6'h22;
          2: cur_fn = 6'h24;
          3: cur_fn = 6'h25;
          4: cur_fn = 6'h27;
          default: cur_fn = 6'h2A;
        endcase
      end
      3: begin
        cur_op = 6'h00;
        do v = 6'($urandom); while (v inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A});
        cur_fn = v;
      end
      4: cur_op = 6'h04;
      5: cur_op = 6'h08;
      6: cur_op = 6'h02;
      default: begin
        do v = 6'($urandom); while (v inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02});
        cur_op = v;
      end
    endcase
    s = stalls();
    repeat (s) cyc(4'd1, 1'b0);
    cyc(4'd1, 1'b1);
    cyc(4'd2, rb());
    s = stalls();
    case (k)
      0: begin cyc(4'd3, rb()); repeat (s) cyc(4'd4, 1'b0); cyc(4'd4, 1'b1); cyc(4'd5, rb()); end
      1: begin cyc(4'd3, rb()); repeat (s) cyc(4'd6, 1'b0); cyc(4'd6, 1'b1); end
      2: begin cyc(4'd7, rb()); cyc(4'd8, rb()); end
      3: begin cyc(4'd7, rb()); cyc(4'd13, rb()); end
      4: cyc(4'd9, rb());
      5: begin cyc(4'd10, rb()); cyc(4'd11, rb()); end
      6: cyc(4'd12, rb());
      default: cyc(4'd13, rb());
    endcase
  endtask

  // Entered at negedge+2 of a FETCH cycle with mem_ready high; leaves in the same spot.
  task automatic cpi(input string nm, input logic [5:0] op, input logic [5:0] fn,
                     input int exp_cpi, input int exp_ill);
    int cnt;
    int ill;
    cnt = 0;
    ill = 0;
    bus.opcode = op;
    bus.funct  = fn;
    bus.zero   = 1'b1;
    bus.mem_ready = 1'b1;
    do begin
      @(negedge clk);
      #2;
      cnt++;
      ill += int'(bus.illegal);
    end while (bus.state != 4'd1 && cnt < 20);
    chk({nm, "_cpi"}, cnt, exp_cpi);
    chk({nm, "_illegal_pulses"}, ill, exp_ill);
  endtask

  initial begin
    int cnt;
    int we;
    int rf;
    int wr;
    bus.opcode = '0;
    bus.funct = '0;
    bus.zero = 1'b1;
    bus.mem_ready = 1'b1;
    cur_op = '0;
    cur_fn = '0;
    exp_v = '0;
    exp_m = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outputs", dv, 22'h0);

    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("fetch_after_reset", dv, 22'h260241);

    cpi("lw",       6'h23, 6'h00, 5, 0);
    cpi("sw",       6'h2B, 6'h00, 4, 0);
    cpi("r_sub",    6'h00, 6'h22, 4, 0);
    cpi("r_badfn",  6'h00, 6'h3F, 4, 1);
    cpi("addi",     6'h08, 6'h00, 4, 0);
    cpi("beq",      6'h04, 6'h00, 3, 0);
    cpi("j",        6'h02, 6'h00, 3, 0);
    cpi("bad_op",   6'h3F, 6'h00, 3, 1);

    // sw with mem_ready low for three MEMWR cycles
    cnt = 0; we = 0; rf = 0; wr = 0;
    bus.opcode = 6'h2B;
    do begin
      @(negedge clk);
      #1;
      if (bus.state == 4'd6) begin
        bus.mem_ready = (wr >= 3);
        wr++;
      end else begin
        bus.mem_ready = 1'b1;
      end
      #1;
      we += int'(bus.MemWE);
      rf += int'(bus.RFWE);
      cnt++;
    end while (bus.state != 4'd1 && cnt < 20);
    chk("sw_stall_memwe_cycles", we, 4);
    chk("sw_stall_rfwe_cycles", rf, 0);
    chk("sw_stall_cpi", cnt, 7);

    // reset asserted while a store is pending
    cnt = 0;
    bus.opcode = 6'h2B;
    do begin
      @(negedge clk);
      #1;
      bus.mem_ready = (bus.state != 4'd6);
      #1;
      cnt++;
    end while (bus.state != 4'd6 && cnt < 20);
    chk("midreset_memwe_before", bus.MemWE, 1);
    rst_n = 1'b0;
    #1;
    chk("midreset_memwe_drop", bus.MemWE, 0);
    chk("midreset_state", bus.state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("midreset_fetch_next", bus.state, 1);

    repeat (400) rand_instr();
    @(negedge clk);
    exp_valid = 1'b0;
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
